// File: rtl/mac_if.sv
// mac_if: operand-in and result-out valid/ready bundle for mac_accumulator
interface mac_if #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_a;
  logic [3:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator: registers operand pairs into a 3x4 multiplier and accumulates products per packet
module four_bit_multiplier (
  input  logic [2:0] A,
  input  logic [3:0] B,
  output logic [6:0] C
);
  assign C = A * B;
endmodule

module mac_accumulator #(
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input logic clk,
  input logic rst,
  mac_if.slave io
);
  typedef enum logic {ACC, DONE} state_t;
  state_t           state;
  logic [2:0]       s1_a;
  logic [3:0]       s1_b;
  logic             s1_valid;
  logic             s1_last;
  logic [6:0]       prod;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             accept;
  logic             cap;
  four_bit_multiplier mul (.A(s1_a), .B(s1_b), .C(prod));
  assign sum          = {1'b0, acc} + (ACC_W+1)'(prod);
  assign accept       = io.in_valid & io.in_ready;
  // terms taken so far = accumulated ones plus the one still sitting in stage 1
  assign cap          = cnt + CNT_W'(s1_valid) + CNT_W'(1) == CNT_W'(MAX_TERMS);
  assign io.in_ready  = (state == ACC) & !rst & !(s1_valid & s1_last);
  assign io.out_valid = state == DONE;
  assign io.out_sum   = acc;
  assign io.out_count = cnt;
  assign io.out_ovf   = ovf;
  // operand capture, accumulation and ACC/DONE sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACC;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= io.in_a;
        s1_b    <= io.in_b;
        s1_last <= io.in_last | cap;
      end
      if (state == ACC && s1_valid) begin
        acc <= sum[ACC_W-1:0];
        cnt <= cnt + CNT_W'(1);
        ovf <= ovf | sum[ACC_W];
        if (s1_last) state <= DONE;
      end
      if (state == DONE && io.out_ready) begin
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
        state <= ACC;
      end
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed stimulus with a result scoreboard for mac_accumulator
module tb_mac_accumulator;
  localparam int ACC_W = 8;
  localparam int CNT_W = 5;
  typedef struct {int sum; int count; int ovf;} exp_t;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t q[$];
  mac_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
  mac_accumulator #(.ACC_W(ACC_W), .MAX_TERMS(4), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .io(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  // result monitor: compares each completed handshake against the scoreboard head
  always begin : mon
    exp_t e;
    @(negedge clk);
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        e = q.pop_front();
        check("out_sum", int'(bus.out_sum), e.sum);
        check("out_count", int'(bus.out_count), e.count);
        check("out_ovf", int'(bus.out_ovf), e.ovf);
      end
    end
  end
  task automatic send(input int a, input int b, input bit last, output int at);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 3'(a);
    bus.in_b     = 4'(b);
    bus.in_last  = last;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept", int'(bus.in_ready), 1);
    at = cyc;
    @(posedge clk);
  endtask
  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, t0, t1, t2, t3, n;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_sum", int'(bus.out_sum), 0);
    check("rst_out_count", int'(bus.out_count), 0);
    check("rst_out_ovf", int'(bus.out_ovf), 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", int'(bus.in_ready), 1);
    q.push_back('{105, 1, 0});
    send(7, 15, 1'b1, t);
    idle();
    check("t1_in_ready", int'(bus.in_ready), 0);
    check("t1_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    check("t2_out_valid", int'(bus.out_valid), 1);
    check("t2_in_ready", int'(bus.in_ready), 0);
    drain();
    bus.out_ready = 1'b0;
    q.push_back('{55, 4, 0});
    send(3, 4, 1'b0, t0);
    send(5, 2, 1'b0, t1);
    send(1, 15, 1'b0, t2);
    send(2, 9, 1'b1, t3);
    check("throughput", t3 - t0, 3);
    idle();
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_out_sum", int'(bus.out_sum), 55);
      check("bp_out_count", int'(bus.out_count), 4);
      check("bp_out_ovf", int'(bus.out_ovf), 0);
      check("bp_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", int'(bus.out_valid), 0);
    check("bp_release_ready", int'(bus.in_ready), 1);
    drain();
    q.push_back('{4, 4, 0});
    q.push_back('{2, 2, 0});
    for (int i = 0; i < 6; i++) send(1, 1, i == 5, t);
    idle();
    drain();
    q.push_back('{59, 3, 1});
    send(7, 15, 1'b0, t);
    send(7, 15, 1'b0, t);
    send(7, 15, 1'b1, t);
    q.push_back('{1, 1, 0});
    send(1, 1, 1'b1, t);
    idle();
    drain();
    send(7, 15, 1'b0, t);
    send(3, 3, 1'b0, t);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_out_sum", int'(bus.out_sum), 0);
    check("midrst_out_count", int'(bus.out_count), 0);
    check("midrst_out_ovf", int'(bus.out_ovf), 0);
    check("midrst_in_ready_after", int'(bus.in_ready), 1);
    q.push_back('{4, 1, 0});
    send(2, 2, 1'b1, t);
    idle();
    drain();
    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
